// File: rtl/vga_text_writer.sv
// Character-stream front end for the VGA text display: accepts bytes, tracks the
// cursor, interprets CR/LF/BS/FF and issues single-cycle cell writes.
module vga_text_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       enter,
  output logic [7:0] data,
  output logic [9:0] dataX,
  output logic [9:0] dataY,
  output logic [9:0] curX,
  output logic [9:0] curY,
  output logic       busy
);

  // state    | meaning
  // IDLE     | waiting for a byte, in_ready high
  // CLR_LINE | blanking row curY, one column per cycle
  // CLR_SCR  | blanking the whole screen row-major
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CLR_LINE = 2'd1;
  localparam logic [1:0] CLR_SCR  = 2'd2;

  localparam logic [9:0] COL_MAX = 10'(COLS - 1);
  localparam logic [9:0] ROW_MAX = 10'(ROWS - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [9:0] clr_x_q, clr_x_d, clr_y_q, clr_y_d;
  logic       enter_q, enter_d;
  logic [7:0] data_q, data_d;
  logic [9:0] dx_q, dx_d, dy_q, dy_d;
  logic [9:0] next_y;

  assign next_y   = (cur_y_q == ROW_MAX) ? 10'd0 : cur_y_q + 10'd1;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign enter    = enter_q;
  assign data     = data_q;
  assign dataX    = dx_q;
  assign dataY    = dy_q;
  assign curX     = cur_x_q;
  assign curY     = cur_y_q;

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    enter_d = 1'b0;
    data_d  = data_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_data)
            8'h0D: cur_x_d = 10'd0;
            8'h0A: begin
              cur_x_d = 10'd0;
              cur_y_d = next_y;
              clr_x_d = 10'd0;
              state_d = CLR_LINE;
            end
            8'h08: begin
              if (cur_x_q != 10'd0) begin
                cur_x_d = cur_x_q - 10'd1;
                enter_d = 1'b1;
                data_d  = BLANK;
                dx_d    = cur_x_q - 10'd1;
                dy_d    = cur_y_q;
              end
            end
            8'h0C: begin
              cur_x_d = 10'd0;
              cur_y_d = 10'd0;
              clr_x_d = 10'd0;
              clr_y_d = 10'd0;
              state_d = CLR_SCR;
            end
            default: begin
              enter_d = 1'b1;
              data_d  = in_data;
              dx_d    = cur_x_q;
              dy_d    = cur_y_q;
              if (cur_x_q == COL_MAX) begin
                // auto-wrap: the new row is blanked before more text lands on it
                cur_x_d = 10'd0;
                cur_y_d = next_y;
                clr_x_d = 10'd0;
                state_d = CLR_LINE;
              end else begin
                cur_x_d = cur_x_q + 10'd1;
              end
            end
          endcase
        end
      end
      CLR_LINE, CLR_SCR: begin
        enter_d = 1'b1;
        data_d  = BLANK;
        dx_d    = clr_x_q;
        dy_d    = (state_q == CLR_SCR) ? clr_y_q : cur_y_q;
        if (clr_x_q == COL_MAX) begin
          clr_x_d = 10'd0;
          if (state_q == CLR_LINE || clr_y_q == ROW_MAX) state_d = IDLE;
          else clr_y_d = clr_y_q + 10'd1;
        end else begin
          clr_x_d = clr_x_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      clr_x_q <= '0;
      clr_y_q <= '0;
      enter_q <= 1'b0;
      data_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
      enter_q <= enter_d;
      data_q  <= data_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

endmodule
